// File: rtl/carfield_domain_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : carfield_domain_rst_seq
// Brief    : Regbus responder that sequences per-domain soft resets
//            (isolate -> reset -> settle -> de-isolate), one domain at a time.
//            Optional isolation-ack timeout: CARFIELD_DOMAIN_RST_SEQ_TIMEOUT_EN
// Revision : 1.0 - initial release
// ============================================================================
module carfield_domain_rst_seq #(
  parameter int unsigned NUM_DOMAINS   = 6,
  parameter int unsigned ADDR_WIDTH    = 48,
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned ISO_TIMEOUT   = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   reg_valid_i,
  input  logic                   reg_write_i,
  input  logic [ADDR_WIDTH-1:0]  reg_addr_i,
  input  logic [31:0]            reg_wdata_i,
  input  logic [3:0]             reg_wstrb_i,
  output logic                   reg_ready_o,
  output logic [31:0]            reg_rdata_o,
  output logic                   reg_error_o,
  output logic [NUM_DOMAINS-1:0] domain_rst_o,
  output logic [NUM_DOMAINS-1:0] domain_iso_o,
  input  logic [NUM_DOMAINS-1:0] domain_iso_ack_i,
  output logic                   seq_done_o
);

  localparam int unsigned c_cntMaxA = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned c_cntMax  = (c_cntMaxA > ISO_TIMEOUT) ? c_cntMaxA : ISO_TIMEOUT;
  localparam int unsigned c_cntW    = (c_cntMax > 1) ? $clog2(c_cntMax) : 1;
  localparam int unsigned c_curW    = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [c_cntW-1:0] c_cntOne    = c_cntW'(1);
  localparam logic [c_cntW-1:0] c_rstLoad   = c_cntW'(RST_CYCLES - 1);
  localparam logic [c_cntW-1:0] c_settleLoad = c_cntW'(SETTLE_CYCLES - 1);
  localparam logic [c_cntW-1:0] c_isoLast   = c_cntW'(ISO_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISO    = 3'd1,
    S_RST    = 3'd2,
    S_SETTLE = 3'd3,
    S_DEISO  = 3'd4
  } state_e;

  state_e                 r_state;
  logic [c_cntW-1:0]      r_cnt;
  logic [c_curW-1:0]      r_cur;
  logic [NUM_DOMAINS-1:0] r_pending;
  logic [NUM_DOMAINS-1:0] r_hold;
  logic [NUM_DOMAINS-1:0] r_rst;
  logic [NUM_DOMAINS-1:0] r_iso;
  logic                   r_done;
  logic                   r_ready;
  logic [31:0]            r_rdata;
  logic                   r_error;

  logic                   w_accept;
  logic [11:0]            w_offs;
  logic                   w_wrPend;
  logic                   w_wrTo;
  logic                   w_wrHold;
  logic [NUM_DOMAINS-1:0] w_wrMask;
  logic [NUM_DOMAINS-1:0] w_pendSet;
  logic [NUM_DOMAINS-1:0] w_pendClr;
  logic [c_curW-1:0]      w_lowIdx;
  logic                   w_ack;
  logic                   w_isoAdv;
  logic                   w_deisoAdv;
  logic [NUM_DOMAINS-1:0] w_timeoutRd;
  logic [7:0]             w_rstPad;
  logic [7:0]             w_isoPad;
  logic [3:0]             w_curPad;
  logic [31:0]            w_status;
  logic [31:0]            w_rdata;
  logic                   w_error;
  logic                   w_unused;

  assign w_accept  = reg_valid_i & ~r_ready;
  assign w_offs    = reg_addr_i[11:0];
  assign w_wrPend  = w_accept & reg_write_i & (w_offs == 12'h000);
  assign w_wrTo    = w_accept & reg_write_i & (w_offs == 12'h008);
  assign w_wrHold  = w_accept & reg_write_i & (w_offs == 12'h00C) & reg_wstrb_i[0];
  // Implemented bits all live in byte 0, so only strobe 0 matters.
  assign w_wrMask  = reg_wstrb_i[0] ? reg_wdata_i[NUM_DOMAINS-1:0] : '0;
  assign w_pendSet = w_wrPend ? w_wrMask : '0;
  assign w_ack     = domain_iso_ack_i[r_cur];

  always_comb begin
    w_lowIdx = '0;
    for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
      if (r_pending[i]) w_lowIdx = c_curW'(i);
    end
  end

  always_comb begin
    w_pendClr = '0;
    if (r_state == S_IDLE && r_pending != '0) w_pendClr[w_lowIdx] = 1'b1;
  end

`ifdef CARFIELD_DOMAIN_RST_SEQ_TIMEOUT_EN
  logic                   w_waitExpired;
  logic [NUM_DOMAINS-1:0] w_toSet;
  logic [NUM_DOMAINS-1:0] w_toClr;
  logic [NUM_DOMAINS-1:0] r_timeout;

  assign w_waitExpired = (r_cnt == c_isoLast);
  assign w_isoAdv      = w_ack | w_waitExpired;
  assign w_deisoAdv    = ~w_ack | w_waitExpired;
  assign w_toClr       = w_wrTo ? w_wrMask : '0;
  assign w_timeoutRd   = r_timeout;

  always_comb begin
    w_toSet = '0;
    if (w_waitExpired && ((r_state == S_ISO && !w_ack) || (r_state == S_DEISO && w_ack)))
      w_toSet[r_cur] = 1'b1;
  end

  // A hardware set outranks a same-cycle software clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_timeout <= '0;
    else       r_timeout <= (r_timeout & ~w_toClr) | w_toSet;
  end
`else
  assign w_isoAdv    = w_ack;
  assign w_deisoAdv  = ~w_ack;
  assign w_timeoutRd = '0;
`endif

  always_comb begin
    w_rstPad = '0;
    w_isoPad = '0;
    w_curPad = '0;
    w_rstPad[NUM_DOMAINS-1:0] = r_rst;
    w_isoPad[NUM_DOMAINS-1:0] = r_iso;
    w_curPad[c_curW-1:0]      = r_cur;
    w_status = {8'h00, w_curPad, r_state, (r_state != S_IDLE), w_isoPad, w_rstPad};
  end

  always_comb begin
    w_rdata = '0;
    w_error = 1'b0;
    case (w_offs)
      12'h000: w_rdata[NUM_DOMAINS-1:0] = r_pending;
      12'h004: begin
        if (reg_write_i) w_error = 1'b1;
        else             w_rdata = w_status;
      end
      12'h008: w_rdata[NUM_DOMAINS-1:0] = w_timeoutRd;
      12'h00C: w_rdata[NUM_DOMAINS-1:0] = r_hold;
      default: w_error = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_error <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_ready <= w_accept;
      r_rdata <= w_accept ? w_rdata : '0;
      r_error <= w_accept & w_error;
      if (w_wrHold) r_hold <= reg_wdata_i[NUM_DOMAINS-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cur     <= '0;
      r_pending <= '0;
      r_rst     <= '0;
      r_iso     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      // Software set outranks the IDLE pick-up clear of the same bit.
      r_pending <= (r_pending & ~w_pendClr) | w_pendSet;
      case (r_state)
        S_IDLE: begin
          if (r_pending != '0) begin
            r_cur           <= w_lowIdx;
            r_iso[w_lowIdx] <= 1'b1;
            r_cnt           <= '0;
            r_state         <= S_ISO;
          end
        end
        S_ISO: begin
          if (w_isoAdv) begin
            r_rst[r_cur] <= 1'b1;
            r_cnt        <= c_rstLoad;
            r_state      <= S_RST;
          end else begin
            r_cnt <= r_cnt + c_cntOne;
          end
        end
        S_RST: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_cntOne;
          end else if (!r_hold[r_cur]) begin
            r_rst[r_cur] <= 1'b0;
            r_cnt        <= c_settleLoad;
            r_state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_cntOne;
          end else begin
            r_iso[r_cur] <= 1'b0;
            r_cnt        <= '0;
            r_state      <= S_DEISO;
          end
        end
        S_DEISO: begin
          if (w_deisoAdv) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + c_cntOne;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign reg_ready_o  = r_ready;
  assign reg_rdata_o  = r_rdata;
  assign reg_error_o  = r_error;
  assign domain_rst_o = r_rst;
  assign domain_iso_o = r_iso;
  assign seq_done_o   = r_done;

  assign w_unused = ^{reg_addr_i[ADDR_WIDTH-1:12], reg_wdata_i[31:NUM_DOMAINS],
                      reg_wstrb_i[3:1], c_isoLast, w_wrTo};

endmodule
`default_nettype wire

// File: tb/tb_carfield_domain_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_carfield_domain_rst_seq
// Brief    : Directed self-checking bench for carfield_domain_rst_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_carfield_domain_rst_seq;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        reg_valid_i;
  logic        reg_write_i;
  logic [47:0] reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic [3:0]  reg_wstrb_i;
  logic        reg_ready_o;
  logic [31:0] reg_rdata_o;
  logic        reg_error_o;
  logic [5:0]  domain_rst_o;
  logic [5:0]  domain_iso_o;
  logic [5:0]  domain_iso_ack_i;
  logic        seq_done_o;

  int nVec = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  carfield_domain_rst_seq dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .reg_valid_i      (reg_valid_i),
    .reg_write_i      (reg_write_i),
    .reg_addr_i       (reg_addr_i),
    .reg_wdata_i      (reg_wdata_i),
    .reg_wstrb_i      (reg_wstrb_i),
    .reg_ready_o      (reg_ready_o),
    .reg_rdata_o      (reg_rdata_o),
    .reg_error_o      (reg_error_o),
    .domain_rst_o     (domain_rst_o),
    .domain_iso_o     (domain_iso_o),
    .domain_iso_ack_i (domain_iso_ack_i),
    .seq_done_o       (seq_done_o)
  );

  // Domain model: isolation ack follows the request three cycles later.
  logic       ackTie0 = 1'b0;
  logic [5:0] isoD1 = '0;
  logic [5:0] isoD2 = '0;
  logic [5:0] isoD3 = '0;
  always @(posedge clk) begin
    isoD1 <= domain_iso_o;
    isoD2 <= isoD1;
    isoD3 <= isoD2;
  end
  assign domain_iso_ack_i = ackTie0 ? 6'h00 : isoD3;

  // Record the order in which domains start and how many completed before.
  logic [5:0] prevIso = '0;
  int doneCnt = 0;
  int startQ[$];
  int doneAtStart[$];
  always @(negedge clk) begin
    if (seq_done_o === 1'b1) doneCnt++;
    for (int i = 0; i < 6; i++) begin
      if (domain_iso_o[i] === 1'b1 && prevIso[i] !== 1'b1) begin
        startQ.push_back(i);
        doneAtStart.push_back(doneCnt);
      end
    end
    prevIso = domain_iso_o;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic regAcc(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, output logic [31:0] rd, output logic er,
                        output int lat);
    reg_valid_i = 1'b1;
    reg_write_i = wr;
    reg_addr_i  = {36'h0, addr};
    reg_wdata_i = wd;
    reg_wstrb_i = strb;
    lat = 0;
    rd  = '0;
    er  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (reg_ready_o === 1'b1) begin
        lat = i;
        rd  = reg_rdata_o;
        er  = reg_error_o;
        break;
      end
    end
    reg_valid_i = 1'b0;
    reg_write_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic wrReg(input string tag, input logic [11:0] addr, input logic [31:0] wd,
                       input logic [3:0] strb, input logic expErr);
    logic [31:0] rd;
    logic        er;
    int          lat;
    regAcc(1'b1, addr, wd, strb, rd, er, lat);
    chk({tag, "_err"}, 32'(er), 32'(expErr));
    chk({tag, "_lat"}, 32'(lat), 32'd1);
  endtask

  task automatic rdChk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    int          lat;
    regAcc(1'b0, addr, 32'h0, 4'hF, rd, er, lat);
    chk({tag, "_data"}, rd, exp);
    chk({tag, "_err"}, 32'(er), 32'd0);
  endtask

  task automatic waitDone(input string tag, input int bound);
    int n = 0;
    while (seq_done_o !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(seq_done_o), 32'h1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    rst_i       = 1'b1;
    reg_valid_i = 1'b0;
    reg_write_i = 1'b0;
    reg_addr_i  = '0;
    reg_wdata_i = '0;
    reg_wstrb_i = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_ready", 32'(reg_ready_o), 32'h0);
    chk("rst_rdata", reg_rdata_o, 32'h0);
    chk("rst_domrst", 32'(domain_rst_o), 32'h0);
    chk("rst_iso", 32'(domain_iso_o), 32'h0);
    chk("rst_done", 32'(seq_done_o), 32'h0);
    rst_i = 1'b0;
    tick();
    rdChk("rst_status", 12'h004, 32'h0);
    rdChk("rst_pend", 12'h000, 32'h0);
    rdChk("rst_hold", 12'h00C, 32'h0);

    // Single domain 3 sequence with timing
    wrReg("t1_wpend", 12'h000, 32'h08, 4'hF, 1'b0);
    chk("t1_iso_up", 32'(domain_iso_o), 32'h08);
    n = 0;
    while (domain_rst_o[3] !== 1'b1 && n < 50) begin tick(); n++; end
    chk("t1_iso_to_rst", 32'(n), 32'd4);
    n = 0;
    while (domain_rst_o[3] === 1'b1 && n < 100) begin tick(); n++; end
    chk("t1_rst_len", 32'(n), 32'd16);
    n = 0;
    while (domain_iso_o[3] === 1'b1 && n < 100) begin tick(); n++; end
    chk("t1_settle_len", 32'(n), 32'd4);
    waitDone("t1_done", 20);
    chk("t1_ack_low_at_done", 32'(domain_iso_ack_i[3]), 32'h0);
    tick();
    chk("t1_done_single", 32'(seq_done_o), 32'h0);
    rdChk("t1_status", 12'h004, 32'h0030_0000);

    // Two domains: lowest index first
    startQ.delete();
    doneAtStart.delete();
    wrReg("t2_wpend", 12'h000, 32'h21, 4'hF, 1'b0);
    rdChk("t2_pend_active", 12'h000, 32'h20);
    waitDone("t2_done_a", 200);
    tick();
    waitDone("t2_done_b", 200);
    tick();
    chk("t2_nstart", 32'(startQ.size()), 32'd2);
    chk("t2_first", 32'(startQ[0]), 32'd0);
    chk("t2_second", 32'(startQ[1]), 32'd5);
    chk("t2_serial", 32'(doneAtStart[1] - doneAtStart[0]), 32'd1);

    // W1S collides with the IDLE pick-up of the same bit: set wins
    startQ.delete();
    wrReg("t2b_w4", 12'h000, 32'h10, 4'hF, 1'b0);
    wrReg("t2b_w0", 12'h000, 32'h01, 4'hF, 1'b0);
    waitDone("t2b_done4", 200);
    wrReg("t2b_w0again", 12'h000, 32'h01, 4'hF, 1'b0);
    rdChk("t2b_pend_kept", 12'h000, 32'h01);
    waitDone("t2b_done0a", 200);
    tick();
    waitDone("t2b_done0b", 200);
    tick();
    rdChk("t2b_pend_empty", 12'h000, 32'h0);
    chk("t2b_nstart", 32'(startQ.size()), 32'd3);
    chk("t2b_order0", 32'(startQ[0]), 32'd4);
    chk("t2b_order1", 32'(startQ[1]), 32'd0);
    chk("t2b_order2", 32'(startQ[2]), 32'd0);

    // HOLD keeps the domain in reset until cleared
    wrReg("t3_whold", 12'h00C, 32'h02, 4'hF, 1'b0);
    wrReg("t3_wpend", 12'h000, 32'h02, 4'hF, 1'b0);
    n = 0;
    while (domain_rst_o[1] !== 1'b1 && n < 50) begin tick(); n++; end
    repeat (30) tick();
    chk("t3_held", 32'(domain_rst_o), 32'h02);
    reg_valid_i = 1'b1;
    reg_write_i = 1'b1;
    reg_addr_i  = 48'h00C;
    reg_wdata_i = 32'h0;
    reg_wstrb_i = 4'hF;
    tick();
    chk("t3_hold_ready", 32'(reg_ready_o), 32'h1);
    chk("t3_still_held", 32'(domain_rst_o), 32'h02);
    reg_valid_i = 1'b0;
    reg_write_i = 1'b0;
    tick();
    chk("t3_released", 32'(domain_rst_o), 32'h00);
    waitDone("t3_done", 50);
    tick();

    // Error accesses and byte strobes
    regAcc(1'b0, 12'h010, 32'h0, 4'hF, rd, er, lat);
    chk("t4_bad_err", 32'(er), 32'h1);
    chk("t4_bad_data", rd, 32'h0);
    chk("t4_bad_lat", 32'(lat), 32'd1);
    wrReg("t4_wstat", 12'h004, 32'hFFFF_FFFF, 4'hF, 1'b1);
    rdChk("t4_status", 12'h004, 32'h0010_0000);
    wrReg("t4_nostrb", 12'h000, 32'h04, 4'h0, 1'b0);
    tick();
    chk("t4_nostrb_iso", 32'(domain_iso_o), 32'h0);
    rdChk("t4_nostrb_pend", 12'h000, 32'h0);
    wrReg("t4_hold_hi", 12'h00C, 32'h3F, 4'hE, 1'b0);
    rdChk("t4_hold_hi_rd", 12'h00C, 32'h0);
    wrReg("t4_hold_all", 12'h00C, 32'hFF, 4'h1, 1'b0);
    rdChk("t4_hold_all_rd", 12'h00C, 32'h3F);
    wrReg("t4_hold_clr", 12'h00C, 32'h00, 4'hF, 1'b0);

`ifdef CARFIELD_DOMAIN_RST_SEQ_TIMEOUT_EN
    // Ack never arrives: sequence advances after the timeout
    ackTie0 = 1'b1;
    wrReg("t5_wpend", 12'h000, 32'h01, 4'hF, 1'b0);
    n = 0;
    while (domain_rst_o[0] !== 1'b1 && n < 400) begin tick(); n++; end
    chk("t5_wait_len", 32'(n), 32'd256);
    waitDone("t5_done", 100);
    tick();
    rdChk("t5_to_set", 12'h008, 32'h01);
    wrReg("t5_w1c", 12'h008, 32'h01, 4'hF, 1'b0);
    rdChk("t5_to_clr", 12'h008, 32'h0);
    ackTie0 = 1'b0;
`else
    rdChk("t5_to_rd", 12'h008, 32'h0);
    wrReg("t5_to_wr", 12'h008, 32'h3F, 4'hF, 1'b0);
    rdChk("t5_to_rd2", 12'h008, 32'h0);
`endif

    // Async reset while domain 2 is in reset
    wrReg("t6_wpend", 12'h000, 32'h04, 4'hF, 1'b0);
    n = 0;
    while (domain_rst_o[2] !== 1'b1 && n < 50) begin tick(); n++; end
    chk("t6_in_rst", 32'(domain_rst_o), 32'h04);
    repeat (3) tick();
    rst_i = 1'b1;
    #1;
    chk("t6_rst_o", 32'(domain_rst_o), 32'h0);
    chk("t6_iso_o", 32'(domain_iso_o), 32'h0);
    chk("t6_done_o", 32'(seq_done_o), 32'h0);
    tick();
    rst_i = 1'b0;
    tick();
    rdChk("t6_status", 12'h004, 32'h0);
    rdChk("t6_pend", 12'h000, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/carfield_domain_rst_seq.md
Name: carfield_domain_rst_seq

Overview:
Register-bus responder in Carfield's external reg space that sequences per-domain soft resets for the periph, safed, secd, integer cluster, FP cluster and L2 domains. Software writes a request mask. One FSM then serves one domain at a time: isolate the domain's AXI ports, hold its reset, release it, let it settle, and de-isolate. The block answers accesses from the Cheshire regbus demux and drives the domain reset and isolation wires.

Parameters:
NumDomains, 6, number of reset domains; legal range 1..8, indices follow the Carfield reset-domain enum.
AddrWidth, 48, regbus address width.
RstCycles, 16, cycles the domain reset is held; must be >=1.
SettleCycles, 4, cycles between reset release and de-isolation; must be >=1.
IsoTimeout, 256, maximum cycles to wait for an isolation ack edge.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
reg_valid_i  in  1  request valid; held high until reg_ready_o
reg_write_i  in  1  1 = write
reg_addr_i  in  AddrWidth  byte address; only bits [11:0] are decoded
reg_wdata_i  in  32  write data
reg_wstrb_i  in  4  byte strobes
reg_ready_o  out  1  one-cycle response strobe
reg_rdata_o  out  32  read data, valid with ready
reg_error_o  out  1  error, valid with ready
domain_rst_o  out  NumDomains  active-high domain soft reset
domain_iso_o  out  NumDomains  active-high isolate request
domain_iso_ack_i  in  NumDomains  isolation status from the domain
seq_done_o  out  1  one-cycle pulse when a domain sequence completes

Behaviour:
- Reset values: all outputs 0; FSM IDLE; PENDING, HOLD and TIMEOUT registers 0; counters 0. domain_rst_o is ORed with the global reset outside this block.
- Regbus handshake: a request is sampled when reg_valid_i=1 and no response is outstanding. reg_ready_o pulses exactly one cycle later, together with rdata and error. The earliest next acceptance is the cycle after ready, so throughput is at most 1 access per 2 cycles.
- Register map (addr[11:0]); writes honour byte strobes; only bits [NumDomains-1:0] are implemented:
  - 0x00 PENDING: read returns the pending mask. Write is W1S.
  - 0x04 STATUS, RO:
    - [7:0] domain_rst_o
    - [15:8] domain_iso_o
    - [16] busy (FSM not IDLE)
    - [19:17] state encoding: IDLE=0, ISO=1, RST=2, SETTLE=3, DEISO=4
    - [23:20] current domain index
  - 0x08 TIMEOUT: W1C; a bit is set when that domain's ack wait timed out.
  - 0x0C HOLD: RW; a set bit keeps the domain in RST after the count expires.
- Error cases: any other offset, or a write to STATUS, returns error=1 and rdata=0 with no side effect.
- FSM:
  - IDLE: if PENDING≠0, pick the lowest set index d, clear PENDING[d], latch cur=d, assert domain_iso_o[d], clear the counter, go ISO.
  - ISO: when domain_iso_ack_i[d]=1, go RST, assert domain_rst_o[d] and load counter=RstCycles-1.
  - RST: decrement the counter. When counter=0 and HOLD[d]=0, deassert domain_rst_o[d], load SettleCycles-1 and go SETTLE. While HOLD[d]=1, stay in RST; clearing HOLD releases on the next cycle.
  - SETTLE: decrement; at 0, deassert domain_iso_o[d], clear the counter, go DEISO.
  - DEISO: when domain_iso_ack_i[d]=0, pulse seq_done_o and go IDLE.
- Simultaneous events:
  - A W1S to PENDING in the same cycle IDLE clears that bit: set wins, and the domain is sequenced again later.
  - A request for the domain currently in sequence only sets PENDING; the active sequence is unaffected.
  - W1C to TIMEOUT in the same cycle as a hardware set: set wins.
- Async reset mid-sequence abandons the sequence: all outputs go to 0 immediately.

Optional Feature:
CARFIELD_DOMAIN_RST_SEQ_TIMEOUT_EN.
- Defined: in ISO and DEISO a counter increments each cycle. On reaching IsoTimeout-1 without the expected ack level, set TIMEOUT[d] and advance as if the ack had arrived.
- Undefined: ISO and DEISO wait indefinitely; TIMEOUT reads 0 and writes to it are accepted with no effect, error=0.

Test Plan:
- Write 0x00=0x08 with the ack following iso after 3 cycles -> iso_o[3] rises. rst_o[3] is high for exactly 16 cycles, then 4 settle cycles, then iso_o[3] falls. seq_done_o pulses once after the ack drops. STATUS.busy returns to 0.
- Write 0x00=0x21 -> domain 0 is fully sequenced before domain 5. PENDING reads 0x20 while domain 0 is active.
- HOLD=0x02, PENDING=0x02 -> rst_o[1] stays high beyond 16 cycles. Writing HOLD=0 releases it on the next cycle.
- Read 0x10 -> error=1, rdata=0. Write 0x04 -> error=1, STATUS unchanged. Each ready pulse arrives 1 cycle after valid.
- With TIMEOUT_EN and the ack tied 0, PENDING=0x01 -> after 256 cycles TIMEOUT reads 0x01 and the sequence completes. A W1C of 0x01 clears it.
- rst_i pulsed while in RST for domain 2 -> rst_o, iso_o and seq_done_o go to 0 immediately. STATUS reads 0 after reset.
